operand_fetch: RTL and testbench

Issue-side companion to the pipeline register file: accepts decoded instructions and issues synchronous read requests on the register file's two read ports. It also tracks in-flight destination registers in a scoreboard and forwards writeback data that the synchronous-read file cannot return. The block sits between decode and execute, drives the file's rs1/rs2/rv inputs, and observes the same writeback bus that drives the file's ws/wd/wv inputs.

---
 rtl/operand_fetch.sv | 193 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch
//
// Issue stage sitting between decode and execute. Accepts one decoded
// instruction at a time, issues a synchronous read on the register file's
// two read ports, and resolves each operand from (in priority order) x0,
// a writeback seen in the issue cycle, a writeback seen in the response
// cycle, or the register-file read data. A scoreboard of in-flight
// destination registers blocks RAW and WAW hazards until the matching
// writeback appears on the writeback bus.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high (in_v/in_ready on the input side, out_v/out_ready on the output
// side). out_v and every out_* field stay stable until that transfer.
//
// Ports
//   clk, reset                     clock, synchronous active-low reset
//   in_v / in_ready                decoded instruction handshake
//   in_rs1, in_rs2, in_use_rs1/2   source indices and their enables
//   in_rd, in_rd_we, in_pc         destination, write enable, tag
//   rf_rs1, rf_rs2, rf_rv          register-file read request
//   rf_rd1, rf_rd2                 register-file read data (cycle after rf_rv)
//   wb_v, wb_rd, wb_data           writeback bus (shared with file write port)
//   out_v / out_ready              operand handshake to execute
//   out_rs1_data, out_rs2_data     resolved operands
//   out_rd, out_rd_we, out_pc      passthrough of the accepted instruction
//   dbg_state, dbg_pend            FSM state and scoreboard, for observation
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    output logic            rf_rv,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_v,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_v,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      dbg_state,
    output logic [31:0]     dbg_pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       pend;       // bit 0 is never set
    logic [31:0]       pend_next;
    logic [4:0]        lat_rs1;
    logic [4:0]        lat_rs2;
    logic              byp1;
    logic              byp2;
    logic [XLEN-1:0]   byp1_data;
    logic [XLEN-1:0]   byp2_data;

    logic              blk_rs1;
    logic              blk_rs2;
    logic              blk_waw;
    logic              hazard;
    logic              slot_free;
    logic              accept;
    logic [XLEN-1:0]   op1_res;
    logic [XLEN-1:0]   op2_res;

    // A pending source is released in the same cycle its writeback appears;
    // the value is then captured through the issue-cycle bypass.
    always_comb begin
        blk_rs1   = in_use_rs1 && pend[in_rs1] && !(wb_v && (wb_rd == in_rs1));
        blk_rs2   = in_use_rs2 && pend[in_rs2] && !(wb_v && (wb_rd == in_rs2));
        blk_waw   = in_rd_we   && pend[in_rd]  && !(wb_v && (wb_rd == in_rd));
        hazard    = blk_rs1 || blk_rs2 || blk_waw;
        slot_free = (state == IDLE) || ((state == HOLD) && out_ready);
        in_ready  = reset && !hazard && slot_free;
        accept    = in_v && in_ready;
    end

    assign rf_rv     = accept;
    assign rf_rs1    = in_rs1;
    assign rf_rs2    = in_rs2;
    assign dbg_state = state;
    assign dbg_pend  = pend;

    // Set beats clear on the same index: the new writer is still in flight.
    always_comb begin
        pend_next = pend;
        if (wb_v && (wb_rd != 5'd0))
            pend_next[wb_rd] = 1'b0;
        if (accept && in_rd_we && (in_rd != 5'd0))
            pend_next[in_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Operand resolution used in the RESP cycle. The file's own
    // read-during-write behaviour is never relied on.
    always_comb begin
        if (lat_rs1 == 5'd0)
            op1_res = '0;
        else if (byp1)
            op1_res = byp1_data;
        else if (wb_v && (wb_rd == lat_rs1))
            op1_res = wb_data;
        else
            op1_res = rf_rd1;

        if (lat_rs2 == 5'd0)
            op2_res = '0;
        else if (byp2)
            op2_res = byp2_data;
        else if (wb_v && (wb_rd == lat_rs2))
            op2_res = wb_data;
        else
            op2_res = rf_rd2;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pend         <= '0;
            out_v        <= 1'b0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_pc       <= '0;
            lat_rs1      <= '0;
            lat_rs2      <= '0;
            byp1         <= 1'b0;
            byp2         <= 1'b0;
            byp1_data    <= '0;
            byp2_data    <= '0;
        end else begin
            pend <= pend_next;

            // Accept only happens in IDLE or on the HOLD handshake, so the
            // passthrough fields never change while out_v is held high.
            if (accept) begin
                lat_rs1   <= in_rs1;
                lat_rs2   <= in_rs2;
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
                out_pc    <= in_pc;
                byp1      <= wb_v && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
                byp2      <= wb_v && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
                byp1_data <= wb_data;
                byp2_data <= wb_data;
            end

            case (state)
                IDLE: begin
                    if (accept)
                        state <= RESP;
                end
                RESP: begin
                    out_rs1_data <= op1_res;
                    out_rs2_data <= op2_res;
                    out_v        <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_v <= 1'b0;
                        state <= accept ? RESP : IDLE;
                    end
                end
                default: begin
                    out_v <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch. A small synchronous register-file model
// (old data on read-during-write) supplies rf_rd1/rf_rd2 and is written by
// the same writeback bus the DUT observes.
module tb_operand_fetch;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            in_v;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic            in_use_rs1;
    logic            in_use_rs2;
    logic [4:0]      in_rd;
    logic            in_rd_we;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic            rf_rv;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic            wb_v;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_v;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic [XLEN-1:0] out_pc;
    logic [1:0]      dbg_state;
    logic [31:0]     dbg_pend;

    logic [XLEN-1:0] mem [32];

    int n_checks;
    int n_errors;

    operand_fetch #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_v         (in_v),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_use_rs1   (in_use_rs1),
        .in_use_rs2   (in_use_rs2),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .in_pc        (in_pc),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rv        (rf_rv),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .wb_v         (wb_v),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_v        (out_v),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_pc       (out_pc),
        .dbg_state    (dbg_state),
        .dbg_pend     (dbg_pend)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model
    always @(posedge clk) begin
        if (rf_rv) begin
            rf_rd1 <= mem[rf_rs1];
            rf_rd2 <= mem[rf_rs2];
        end
        if (wb_v && (wb_rd != 5'd0))
            mem[wb_rd] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply at the
    // following edge, and outputs read here are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] pc);
        in_v       = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_rs1 = u1;
        in_use_rs2 = u2;
        in_rd      = rd;
        in_rd_we   = we;
        in_pc      = pc;
        #1;
    endtask

    task automatic no_issue();
        in_v = 1'b0;
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_v    = v;
        wb_rd   = rd;
        wb_data = d;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3] = 32'h11;
        mem[4] = 32'h22;
        mem[6] = 32'h66;
        rf_rd1 = '0;
        rf_rd2 = '0;
        reset = 1'b0;
        out_ready = 1'b0;
        wb_v = 1'b0; wb_rd = '0; wb_data = '0;
        issue(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0);

        // ---- reset state
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_rf_rv", {31'b0, rf_rv}, 32'd0);
        tick();
        tick();
        check("rst_out_v", {31'b0, out_v}, 32'd0);
        check("rst_out_rs1", out_rs1_data, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_pend", dbg_pend, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        no_issue();
        reset = 1'b1;
        tick();

        // ---- basic read, latency N / N+1 / N+2
        issue(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 32'h100);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_rf_rv", {31'b0, rf_rv}, 32'd1);
        check("t1_rf_rs", {22'b0, rf_rs1, rf_rs2}, {22'b0, 5'd3, 5'd4});
        tick();
        no_issue();
        check("t1_resp_out_v", {31'b0, out_v}, 32'd0);
        check("t1_resp_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("t1_out_v", {31'b0, out_v}, 32'd1);
        check("t1_rs1", out_rs1_data, 32'h11);
        check("t1_rs2", out_rs2_data, 32'h22);
        check("t1_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_done_out_v", {31'b0, out_v}, 32'd0);

        // ---- held output, RAW stall released by writeback in issue cycle
        issue(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 32'h200);
        tick();
        no_issue();
        check("t2_pend5", dbg_pend, 32'h20);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_v", {31'b0, out_v}, 32'd1);
            check("t2_hold_rd", {26'b0, out_rd_we, out_rd}, {26'b0, 1'b1, 5'd5});
            check("t2_hold_pc", out_pc, 32'h200);
            check("t2_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        issue(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h210);
        check("t2_stall_hold", {31'b0, in_ready}, 32'd0);
        tick();
        check("t2_idle_out_v", {31'b0, out_v}, 32'd0);
        check("t2_stall_idle", {31'b0, in_ready}, 32'd0);
        tick();
        check("t2_stall_idle2", {31'b0, in_ready}, 32'd0);
        wb(1'b1, 5'd5, 32'hABCD);
        check("t2_release", {31'b0, in_ready}, 32'd1);
        tick();
        no_issue();
        wb(1'b0, 5'd0, 32'h0);
        out_ready = 1'b0;
        tick();
        check("t2_out_v", {31'b0, out_v}, 32'd1);
        check("t2_byp_rs1", out_rs1_data, 32'hABCD);
        check("t2_pend_clear", dbg_pend, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- writeback during RESP overrides stale file data
        issue(5'd3, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 32'h300);
        tick();
        no_issue();
        wb(1'b1, 5'd7, 32'h55);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("t3_rs2_wb", out_rs2_data, 32'h55);
        check("t3_rs1_rf", out_rs1_data, 32'h11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- x0 sources and x0 destination
        wb(1'b1, 5'd0, 32'hFFFF);
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 32'h400);
        tick();
        no_issue();
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("t4_rs1_zero", out_rs1_data, 32'd0);
        check("t4_rs2_zero", out_rs2_data, 32'd0);
        check("t4_pend", dbg_pend, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---- set beats clear; back-to-back accept drops out_v one cycle
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h500);
        tick();
        no_issue();
        tick();
        check("t5_pend9", dbg_pend, 32'h200);
        out_ready = 1'b1;
        wb(1'b1, 5'd9, 32'h99);
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h501);
        check("t5_waw_release", {31'b0, in_ready}, 32'd1);
        tick();
        no_issue();
        wb(1'b0, 5'd0, 32'h0);
        out_ready = 1'b0;
        check("t5_b2b_out_v", {31'b0, out_v}, 32'd0);
        check("t5_b2b_state", {30'b0, dbg_state}, 32'd1);
        check("t5_set_wins", dbg_pend, 32'h200);
        tick();
        check("t5_out_v", {31'b0, out_v}, 32'd1);
        check("t5_pc", out_pc, 32'h501);
        out_ready = 1'b1;
        issue(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h502);
        check("t5_raw_stall", {31'b0, in_ready}, 32'd0);
        tick();
        no_issue();
        check("t5_raw_stall_idle", {31'b0, in_ready}, 32'd0);
        wb(1'b1, 5'd9, 32'h9);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        out_ready = 1'b0;

        // ---- reset while holding with an in-flight destination
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 32'h600);
        tick();
        no_issue();
        tick();
        check("t6_hold_v", {31'b0, out_v}, 32'd1);
        check("t6_pend6", dbg_pend, 32'h40);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_rst_out_v", {31'b0, out_v}, 32'd0);
        check("t6_rst_pend", dbg_pend, 32'd0);
        check("t6_rst_pc", out_pc, 32'd0);
        issue(5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h610);
        check("t6_no_stall", {31'b0, in_ready}, 32'd1);
        tick();
        no_issue();
        tick();
        check("t6_out_v", {31'b0, out_v}, 32'd1);
        check("t6_rs1", out_rs1_data, 32'h66);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
